wfg_wb_master: RTL and testbench
================================

WFG_WB_MASTER -- requirements
Module: wfg_wb_master

Interface
REQ-001 Parameter BUSW, default 32: Wishbone address/data width in bits.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for io_wbs_ack before an access is aborted.
REQ-003 io_wbs_clk  input  1  single clock; all logic rising-edge.
REQ-004 io_wbs_rst  input  1  reset; asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_we  input  1  1 = write, 0 = read.
REQ-008 cmd_adr  input  BUSW  target byte address.
REQ-009 cmd_wdata  input  BUSW  write data.
REQ-010 rsp_valid  output  1  response pulse, one cycle.
REQ-011 rsp_rdata  output  BUSW  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  access timed out; qualified by rsp_valid.
REQ-013 io_wbs_adr  output  BUSW  Wishbone address.
REQ-014 io_wbs_datwr  output  BUSW  Wishbone write data.
REQ-015 io_wbs_datrd  input  BUSW  Wishbone read data.
REQ-016 io_wbs_we  output  1  Wishbone write enable.
REQ-017 io_wbs_stb  output  1  Wishbone strobe.
REQ-018 io_wbs_cyc  output  1  Wishbone cycle.
REQ-019 io_wbs_ack  input  1  Wishbone acknowledge from responder.

Function
REQ-020 FSM states: IDLE, BUS, RESP.
REQ-021 In IDLE, cmd_ready shall be 1.
- In BUS and RESP, cmd_ready shall be 0.
REQ-022 Command acceptance:
- cmd_valid & cmd_ready at a clock edge registers cmd_we/cmd_adr/cmd_wdata onto io_wbs_we/io_wbs_adr/io_wbs_datwr.
- The same edge sets io_wbs_cyc = io_wbs_stb = 1 and moves to BUS.
- Bus outputs are registered: cyc/stb rise the cycle after acceptance.
REQ-023 In BUS:
- adr, datwr, we, cyc and stb shall hold stable until ack or timeout.
- A wait counter shall increment once per cycle.
REQ-024 If io_wbs_ack = 1 in BUS:
- Capture io_wbs_datrd if a read, else capture 0.
- Drop cyc/stb at that edge.
- Move to RESP.
REQ-025 If no ack arrives within TIMEOUT cycles of cyc rising:
- Drop cyc/stb.
- Set the error flag and capture rdata = 0.
- Move to RESP.
- Ack and timeout on the same cycle: ack wins, err = 0.
REQ-026 In RESP:
- rsp_valid = 1 for exactly one cycle, with rsp_rdata/rsp_err valid alongside it.
- Then return to IDLE.
- Command-to-command throughput is at most one access per 3 + wait cycles.
REQ-027 A command whose cmd_valid rises during BUS or RESP is held off by cmd_ready = 0; it shall not be dropped provided the requester holds cmd_valid.
REQ-028 io_wbs_ack received in IDLE or RESP shall be ignored (no state or data change).
REQ-029 Wait counter width: $clog2(TIMEOUT+1); cleared on acceptance; shall never wrap.
REQ-030 Outside BUS, io_wbs_cyc and io_wbs_stb shall be 0; io_wbs_datwr shall be 0 after any read command.

Reset
REQ-031 io_wbs_rst low shall immediately force:
- State IDLE; wait counter 0.
- Outputs: cyc 0, stb 0, we 0, adr 0, datwr 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, cmd_ready 0.
REQ-032 Reset asserted mid-access shall abort the access with no response generated.
- The first post-reset cycle shall show cmd_ready = 1.

Structure
REQ-033 The FSM state enum shall live in the shared package wfg_pkg, alongside the default TIMEOUT constant.
REQ-034 The design shall be a single flat module with no sub-modules.

Verification
REQ-035 Write, responder acks 2 cycles after stb: cmd_we=1, adr=0x04, wdata=0xDEADBEEF.
- Bus holds 0x04/0xDEADBEEF with we=1 until ack.
- rsp_valid pulses with err=0, rdata=0.
REQ-036 Read, responder returns 0x12345678 with 0-wait ack: adr=0x10.
- rsp_rdata = 0x12345678, err = 0; cyc high exactly one cycle.
REQ-037 Timeout, TIMEOUT=16, responder never acks:
- cyc drops after 16 cycles.
- rsp_err = 1, rsp_rdata = 0; next command accepted afterwards.
REQ-038 Ack exactly on cycle 16 (same cycle as timeout): rsp_err = 0 and read data returned.
REQ-039 Back-to-back commands, cmd_valid held high with two queued commands:
- Second command accepted only after the first rsp_valid.
- Both complete in order.
REQ-040 Reset asserted while in BUS:
- cyc/stb = 0 immediately, no rsp_valid.
- cmd_ready = 1 on the first cycle after deassert; a stray ack in IDLE produces no response.

Source files
------------

// File: rtl/wfg_pkg.sv
// wfg_pkg: shared FSM state encoding and default access timeout for the Wishbone master
package wfg_pkg;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_state_e;
endpackage

// File: rtl/wfg_wb_master.sv
// wfg_wb_master: single-command Wishbone master with ack timeout.
//   io_wbs_clk/io_wbs_rst      : clock, async active-low reset
//   cmd_valid/ready/we/adr/wdata: command handshake from requester
//   rsp_valid/rdata/err         : one-cycle response (err = ack timeout)
//   io_wbs_*                    : registered Wishbone master bus
module wfg_wb_master
  import wfg_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [BUSW-1:0] cmd_adr,
  input  logic [BUSW-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [BUSW-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [BUSW-1:0] io_wbs_adr,
  output logic [BUSW-1:0] io_wbs_datwr,
  input  logic [BUSW-1:0] io_wbs_datrd,
  output logic            io_wbs_we,
  output logic            io_wbs_stb,
  output logic            io_wbs_cyc,
  input  logic            io_wbs_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d, we_q, we_d, err_q, err_d;
  logic [BUSW-1:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst) begin
    if (!io_wbs_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = BUS;
        cnt_d   = '0;
        cyc_d   = 1'b1;
        we_d    = cmd_we;
        adr_d   = cmd_adr;
        // reads drive zero write data so no stale payload lingers on the bus
        dat_d   = cmd_we ? cmd_wdata : '0;
      end
      BUS: begin
        // counter saturates at TIMEOUT when the access is abandoned
        cnt_d = cnt_q + 1'b1;
        if (io_wbs_ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : io_wbs_datrd;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready    = (state_q == IDLE) && io_wbs_rst;
  assign rsp_valid    = state_q == RESP;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign io_wbs_adr   = adr_q;
  assign io_wbs_datwr = dat_q;
  assign io_wbs_we    = we_q;
  assign io_wbs_cyc   = cyc_q;
  assign io_wbs_stb   = cyc_q;
endmodule

// File: tb/tb_wfg_wb_master.sv
// tb_wfg_wb_master: directed self-checking bench for wfg_wb_master
module tb_wfg_wb_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, io_wbs_adr, io_wbs_datwr;
  logic [31:0] datrd = '0;
  logic        ack = 1'b0;
  logic        io_wbs_we, io_wbs_stb, io_wbs_cyc;
  int          n_cmp = 0, n_bad = 0;
  int          cycn = 0;
  logic [31:0] acc_a[$], rsp_d[$];
  int          acc_t[$], rsp_t[$];
  logic [31:0] r_data;
  logic        r_err;
  int          ncyc;

  wfg_wb_master #(.BUSW(32), .TIMEOUT(16)) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_wbs_adr(io_wbs_adr), .io_wbs_datwr(io_wbs_datwr), .io_wbs_datrd(datrd),
    .io_wbs_we(io_wbs_we), .io_wbs_stb(io_wbs_stb), .io_wbs_cyc(io_wbs_cyc),
    .io_wbs_ack(ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_a.push_back(cmd_adr);
      acc_t.push_back(cycn);
    end
    if (rsp_valid) begin
      rsp_d.push_back(rsp_rdata);
      rsp_t.push_back(cycn);
    end
    cycn <= cycn + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ack_at: 1-based cycle of cyc on which the responder acks; 0 = never
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd,
                        output logic [31:0] o_data, output logic o_err, output int o_ncyc);
    logic hold;
    int   guard;
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_wdata = wd; datrd = rd;
    @(negedge clk);
    cmd_valid = 0; cmd_adr = 32'hFFFF_FFF0; cmd_wdata = 32'h0BAD_0BAD;
    hold = 1; o_ncyc = 0; guard = 0;
    while (io_wbs_cyc && guard < 64) begin
      o_ncyc++;
      hold = hold && io_wbs_stb && (io_wbs_we == we) && (io_wbs_adr == adr) &&
             (io_wbs_datwr == (we ? wd : 32'h0)) && !rsp_valid && !cmd_ready;
      ack = (o_ncyc == ack_at);
      @(negedge clk);
      guard++;
    end
    chk("bus_bound", guard < 64, 1);
    chk("bus_hold", hold, 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("resp_ready", cmd_ready, 0);
    chk("resp_stb", io_wbs_stb, 0);
    o_data = rsp_rdata; o_err = rsp_err;
    ack = 1; datrd = 32'h7777_7777;
    @(negedge clk);
    ack = 0;
    chk("rsp_pulse", rsp_valid, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_cyc", io_wbs_cyc, 0);
  endtask

  initial begin
    #1;
    chk("rst_cyc", io_wbs_cyc, 0);
    chk("rst_stb", io_wbs_stb, 0);
    chk("rst_we", io_wbs_we, 0);
    chk("rst_adr", io_wbs_adr, 0);
    chk("rst_datwr", io_wbs_datwr, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("post_rst_ready", cmd_ready, 1);

    do_cmd(1, 32'h04, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D, r_data, r_err, ncyc);
    chk("wr_rdata", r_data, 0);
    chk("wr_err", r_err, 0);
    chk("wr_ncyc", ncyc, 3);

    do_cmd(0, 32'h10, 32'h9999_9999, 1, 32'h1234_5678, r_data, r_err, ncyc);
    chk("rd_rdata", r_data, 32'h1234_5678);
    chk("rd_err", r_err, 0);
    chk("rd_ncyc", ncyc, 1);
    chk("rd_datwr_zero", io_wbs_datwr, 0);

    do_cmd(0, 32'h30, 32'h0, 0, 32'h55AA_55AA, r_data, r_err, ncyc);
    chk("to_rdata", r_data, 0);
    chk("to_err", r_err, 1);
    chk("to_ncyc", ncyc, 16);

    do_cmd(1, 32'h34, 32'h0102_0304, 2, 32'hFFFF_FFFF, r_data, r_err, ncyc);
    chk("after_to_err", r_err, 0);
    chk("after_to_ncyc", ncyc, 2);

    do_cmd(0, 32'h40, 32'h0, 16, 32'hA1B2_C3D4, r_data, r_err, ncyc);
    chk("ack16_rdata", r_data, 32'hA1B2_C3D4);
    chk("ack16_err", r_err, 0);
    chk("ack16_ncyc", ncyc, 16);

    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (acc_a.size() == 6) cmd_adr = 32'h24;
      if (acc_a.size() == 7) cmd_valid = 0;
      ack = io_wbs_cyc;
      datrd = io_wbs_adr ^ 32'h5A5A_0000;
    end
    ack = 0;
    chk("b2b_acc_cnt", acc_a.size(), 7);
    chk("b2b_rsp_cnt", rsp_d.size(), 7);
    chk("b2b_acc0", acc_a[5], 32'h20);
    chk("b2b_acc1", acc_a[6], 32'h24);
    chk("b2b_rsp0", rsp_d[5], 32'h5A5A_0020);
    chk("b2b_rsp1", rsp_d[6], 32'h5A5A_0024);
    chk("b2b_holdoff", acc_t[6], rsp_t[5] + 1);

    @(negedge clk);
    cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h50; cmd_wdata = 32'h1111_2222;
    @(negedge clk);
    cmd_valid = 0;
    chk("rb_cyc_pre", io_wbs_cyc, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rb_cyc", io_wbs_cyc, 0);
    chk("rb_stb", io_wbs_stb, 0);
    chk("rb_ready", cmd_ready, 0);
    chk("rb_adr", io_wbs_adr, 0);
    chk("rb_datwr", io_wbs_datwr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rb_ready_post", cmd_ready, 1);
    ack = 1; datrd = 32'hDDDD_DDDD;
    repeat (3) @(negedge clk);
    ack = 0;
    chk("rb_no_rsp", rsp_d.size(), 7);
    chk("rb_stray_cyc", io_wbs_cyc, 0);
    chk("rb_stray_ready", cmd_ready, 1);

    do_cmd(0, 32'h60, 32'h0, 2, 32'h0F0F_0F0F, r_data, r_err, ncyc);
    chk("final_rdata", r_data, 32'h0F0F_0F0F);
    chk("final_err", r_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
